// File: rtl/modulo_controle_transferencia_rolhas_pkg.sv
// ---------------------------------------------------------------------------
// modulo_controle_transferencia_rolhas_pkg
// Shared definitions for the cork-transfer stage: FSM state encoding, the
// default reservoir limits, the counter widths and the burst-size helper.
// ---------------------------------------------------------------------------
package modulo_controle_transferencia_rolhas_pkg;

  localparam int W_PRINC = 5;   // primary buffer count width (0..20)
  localparam int W_SEC   = 7;   // secondary reservoir count width (0..99)

  localparam int CAP_PRINC_DEF = 20;
  localparam int MIN_PRINC_DEF = 5;
  localparam int LOTE_DEF      = 15;
  localparam int CAP_SEC_DEF   = 99;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    TRANSF = 2'b01,
    FIM    = 2'b10
  } estado_t;

  // Burst size is the smallest of: the burst limit, what the secondary
  // holds, and the free room in the primary. The result always fits in the
  // 5-bit burst counter because the burst limit does.
  function automatic logic [W_PRINC-1:0] tamanho_lote(
    input logic [W_SEC-1:0] lote,
    input logic [W_SEC-1:0] disponivel,
    input logic [W_SEC-1:0] espaco
  );
    logic [W_SEC-1:0] m;
    m = lote;
    if (disponivel < m) m = disponivel;
    if (espaco < m)     m = espaco;
    return m[W_PRINC-1:0];
  endfunction

endpackage

// File: rtl/modulo_contador_sync_5_bits_burst.sv
// ---------------------------------------------------------------------------
// modulo_contador_sync_5_bits_burst
// Loadable 5-bit down-counter holding the corks still to move in the
// current refill burst. Load has priority over decrement; the count
// saturates at zero.
//   clk      : system tick
//   clr      : asynchronous active-low reset
//   load     : load load_val on the next edge
//   load_val : burst size
//   dec      : one cork moved this cycle
//   count    : corks remaining in the burst
//   zero     : count == 0
// ---------------------------------------------------------------------------
module modulo_contador_sync_5_bits_burst
  import modulo_controle_transferencia_rolhas_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic [W_PRINC-1:0] load_val,
  input  logic               dec,
  output logic [W_PRINC-1:0] count,
  output logic               zero
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/modulo_controle_transferencia_rolhas.sv
// ---------------------------------------------------------------------------
// modulo_controle_transferencia_rolhas
// Cork reservoir stage: secondary reservoir (0..99) refills the primary
// dispenser buffer (0..20) one cork per tick in bursts; operator loads go
// into the secondary, sealing events consume from the primary.
//   clk            : system tick (divided clock)
//   clr            : asynchronous active-low reset
//   enable         : start_stop, refill allowed only while high
//   add_valid      : single-cycle load request
//   add_qtd        : corks to add to the secondary
//   vedacao        : single-cycle seal pulse, consumes one primary cork
//   buf_principal  : primary buffer count
//   buf_secundario : secondary reservoir count
//   ro             : primary empty
//   add_ack        : pulse, load accepted
//   add_rej        : pulse, load rejected
//   vedacao_err    : pulse, seal requested with empty primary
//   transferindo   : high while a burst is in progress
//   transf_fim     : pulse on burst completion
//   estado         : FSM state
// ---------------------------------------------------------------------------
module modulo_controle_transferencia_rolhas
  import modulo_controle_transferencia_rolhas_pkg::*;
#(
  parameter int CAP_PRINC = CAP_PRINC_DEF,
  parameter int MIN_PRINC = MIN_PRINC_DEF,
  parameter int LOTE      = LOTE_DEF,
  parameter int CAP_SEC   = CAP_SEC_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               enable,
  input  logic               add_valid,
  input  logic [W_SEC-1:0]   add_qtd,
  input  logic               vedacao,
  output logic [W_PRINC-1:0] buf_principal,
  output logic [W_SEC-1:0]   buf_secundario,
  output logic               ro,
  output logic               add_ack,
  output logic               add_rej,
  output logic               vedacao_err,
  output logic               transferindo,
  output logic               transf_fim,
  output logic [1:0]         estado
);

  estado_t            estado_q;
  logic [W_PRINC-1:0] prim_q;
  logic [W_SEC-1:0]   sec_q;

  logic [W_PRINC-1:0] burst_count;
  logic               burst_zero;
  logic               burst_last;
  logic [W_PRINC-1:0] burst_size;

  logic               inicio;
  logic               move;
  logic               seal_ok;
  logic               accept;
  logic [W_SEC-1:0]   sec_base;
  logic [W_SEC:0]     soma;
  logic [W_PRINC-1:0] prim_next;
  logic [W_SEC-1:0]   sec_next;

  // A burst may start only from idle; the size is taken from the current
  // registered counts, which is safe because a same-cycle seal only frees
  // room and a same-cycle load only adds corks.
  assign inicio = (estado_q == OCIOSO) && enable
                  && (prim_q < W_PRINC'(MIN_PRINC)) && (sec_q != '0);

  assign burst_size = tamanho_lote(W_SEC'(LOTE), sec_q,
                                   W_SEC'(CAP_PRINC) - {2'b00, prim_q});

  // The burst count never exceeds the secondary contents or the primary
  // free room, so a move can never underflow the secondary or overflow
  // the primary.
  assign move       = (estado_q == TRANSF) && enable && !burst_zero;
  assign burst_last = (burst_count == W_PRINC'(1));

  assign seal_ok = vedacao && (prim_q != '0);

  // The load check sees the secondary as it will be after this cycle's
  // move; the extra bit keeps the sum from wrapping.
  assign sec_base = sec_q - {{(W_SEC-1){1'b0}}, move};
  assign soma     = {1'b0, sec_base} + {1'b0, add_qtd};
  assign accept   = add_valid && (add_qtd != '0) && (soma <= (W_SEC+1)'(CAP_SEC));

  assign prim_next = prim_q + {{(W_PRINC-1){1'b0}}, move}
                            - {{(W_PRINC-1){1'b0}}, seal_ok};
  assign sec_next  = accept ? (sec_base + add_qtd) : sec_base;

  modulo_contador_sync_5_bits_burst u_contador_burst (
    .clk      (clk),
    .clr      (clr),
    .load     (inicio),
    .load_val (burst_size),
    .dec      (move),
    .count    (burst_count),
    .zero     (burst_zero)
  );

  // Counters, pulse outputs and state all update together so that
  // simultaneous move/seal/load events net into a single edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      estado_q    <= OCIOSO;
      prim_q      <= '0;
      sec_q       <= '0;
      add_ack     <= 1'b0;
      add_rej     <= 1'b0;
      vedacao_err <= 1'b0;
      transf_fim  <= 1'b0;
    end else begin
      prim_q      <= prim_next;
      sec_q       <= sec_next;
      add_ack     <= accept;
      add_rej     <= add_valid && !accept;
      vedacao_err <= vedacao && (prim_q == '0);
      transf_fim  <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (inicio) estado_q <= TRANSF;
        end
        TRANSF: begin
          // Dropping enable aborts the burst without a completion pulse.
          if (!enable || burst_zero) begin
            estado_q <= OCIOSO;
          end else if (burst_last) begin
            estado_q   <= FIM;
            transf_fim <= 1'b1;
          end
        end
        FIM: begin
          estado_q <= OCIOSO;
        end
        default: begin
          estado_q <= OCIOSO;
        end
      endcase
    end
  end

  assign buf_principal  = prim_q;
  assign buf_secundario = sec_q;
  assign ro             = (prim_q == '0);
  assign transferindo   = (estado_q == TRANSF);
  assign estado         = estado_q;

endmodule
